mu0_demux16: RTL

//  Registered 1-to-2 demultiplexer for 16-bit MU0 datapath words: steers each accepted input

---
 rtl/mu0_pkg.sv | 15 +
 rtl/mu0_demux16_if.sv | 29 ++
 rtl/mu0_fifo16.sv | 62 ++++++
 rtl/mu0_demux16.sv | 77 +++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared constants and pointer-width helper for the MU0 word demux
package mu0_pkg;

  localparam int MU0_WIDTH = 16;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mu0_demux16_if.sv
// rtl/mu0_demux16_if.sv - producer and dual-sink handshake bundle for mu0_demux16
interface mu0_demux16_if
  import mu0_pkg::*;
#(
  parameter int WIDTH = MU0_WIDTH
);

  logic [WIDTH-1:0] D;
  logic             S;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] QA;
  logic             QAValid;
  logic             QAReady;
  logic [WIDTH-1:0] QB;
  logic             QBValid;
  logic             QBReady;

  modport master (
    output D, S, InValid, QAReady, QBReady,
    input  InReady, QA, QAValid, QB, QBValid
  );

  modport slave (
    input  D, S, InValid, QAReady, QBReady,
    output InReady, QA, QAValid, QB, QBValid
  );

endinterface

// File: rtl/mu0_fifo16.sv
// rtl/mu0_fifo16.sv - synchronous word FIFO with separate occupancy counter
// Head shows storage[rd_ptr] while non-empty and the last popped word when empty.
module mu0_fifo16
  import mu0_pkg::*;
#(
  parameter int WIDTH = MU0_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mu0_demux16.sv
// rtl/mu0_demux16.sv - registered 1-to-2 word demux with a FIFO per output
// Optional pop counters CntA/CntB are built when MU0_DEMUX_STATS_EN is defined.
module mu0_demux16
  import mu0_pkg::*;
#(
  parameter int WIDTH = MU0_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic          Clk,
  input  logic          nReset,
  mu0_demux16_if.slave  bus
`ifdef MU0_DEMUX_STATS_EN
  ,
  output logic [15:0]   CntA,
  output logic [15:0]   CntB
`endif
);

  logic w_full_a;
  logic w_full_b;
  logic w_empty_a;
  logic w_empty_b;
  logic w_push_a;
  logic w_push_b;
  logic w_pop_a;
  logic w_pop_b;

  // Ready depends only on S and occupancy, so D can never stall the producer.
  assign bus.InReady = (bus.S == SEL_B) ? ~w_full_b : ~w_full_a;
  assign w_push_a    = bus.InValid & bus.InReady & (bus.S == SEL_A);
  assign w_push_b    = bus.InValid & bus.InReady & (bus.S == SEL_B);
  assign bus.QAValid = ~w_empty_a;
  assign bus.QBValid = ~w_empty_b;
  assign w_pop_a     = bus.QAValid & bus.QAReady;
  assign w_pop_b     = bus.QBValid & bus.QBReady;

  mu0_fifo16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .Clk     (Clk),
    .nReset  (nReset),
    .i_push  (w_push_a),
    .i_data  (bus.D),
    .i_pop   (w_pop_a),
    .o_full  (w_full_a),
    .o_empty (w_empty_a),
    .o_head  (bus.QA)
  );

  mu0_fifo16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .Clk     (Clk),
    .nReset  (nReset),
    .i_push  (w_push_b),
    .i_data  (bus.D),
    .i_pop   (w_pop_b),
    .o_full  (w_full_b),
    .o_empty (w_empty_b),
    .o_head  (bus.QB)
  );

`ifdef MU0_DEMUX_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_pop_a && (r_cnt_a != 16'hFFFF)) r_cnt_a <= r_cnt_a + 16'd1;
      if (w_pop_b && (r_cnt_b != 16'hFFFF)) r_cnt_b <= r_cnt_b + 16'd1;
    end
  end

  assign CntA = r_cnt_a;
  assign CntB = r_cnt_b;
`endif

endmodule
